// File: rtl/qcw_ramp_gen_if.sv
// Control/config/status bundle between the power-interface side and the QCW ramp generator.
// The slave modport is the generator; the master modport is whoever drives start and config.
interface qcw_ramp_gen_if #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned CNT_W   = 16
);
  logic                       start;
  logic                       halt;
  logic                       qcw_done;
  logic                       cycle_finished;
  logic [PHASE_W-1:0]         phase_start;
  logic [PHASE_W-1:0]         phase_end;
  logic [PHASE_W+FRAC_W-1:0]  phase_step;
  logic [CNT_W-1:0]           hold_cycles;

  logic [PHASE_W-1:0]         phase_shift;
  logic                       busy;
  logic                       ramp_done;
  logic                       aborted;
  logic [CNT_W-1:0]           cycle_count;

  modport master (
    output start, halt, qcw_done, cycle_finished,
    output phase_start, phase_end, phase_step, hold_cycles,
    input  phase_shift, busy, ramp_done, aborted, cycle_count
  );

  modport slave (
    input  start, halt, qcw_done, cycle_finished,
    input  phase_start, phase_end, phase_step, hold_cycles,
    output phase_shift, busy, ramp_done, aborted, cycle_count
  );
endinterface

// File: rtl/qcw_ramp_gen.sv
// Per-bridge-cycle phase-shift envelope: ramps phase_start -> phase_end, then holds phase_end.
// Define QCW_RAMP_ROUND_EN for round-half-up phase output instead of truncation.
module qcw_ramp_gen #(
  parameter int unsigned PHASE_W = 8,
  parameter int unsigned FRAC_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic            clk_i,
  input  logic            reset_i,
  qcw_ramp_gen_if.slave   bus
);
  localparam int unsigned AccW = PHASE_W + FRAC_W;

  typedef enum logic [1:0] {StIdle, StRamp, StHold, StFinish} state_e;

  state_e              state_q;
  logic [AccW-1:0]     acc_q;
  logic [AccW-1:0]     step_q;
  logic [PHASE_W-1:0]  end_q;
  logic [PHASE_W-1:0]  phase_q;
  logic [CNT_W-1:0]    hold_q;
  logic [CNT_W-1:0]    hold_cnt_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                dir_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic [AccW-1:0]     target;
  logic [AccW:0]       sum;
  logic [AccW:0]       diff;
  logic                reach;
  logic [AccW-1:0]     acc_d;
  logic [PHASE_W-1:0]  phase_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                abort;
`ifdef QCW_RAMP_ROUND_EN
  logic [PHASE_W:0]    rounded;
`endif

  always_comb begin
    target = {end_q, {FRAC_W{1'b0}}};
    // One extra bit catches carry past the top of range and borrow below zero.
    sum    = {1'b0, acc_q} + {1'b0, step_q};
    diff   = {1'b0, acc_q} - {1'b0, step_q};
    if (dir_q) begin
      reach = (sum >= {1'b0, target});
    end else begin
      reach = diff[AccW] || (diff[AccW-1:0] <= target);
    end
    if (reach) begin
      acc_d = target;
    end else if (dir_q) begin
      acc_d = sum[AccW-1:0];
    end else begin
      acc_d = diff[AccW-1:0];
    end
`ifdef QCW_RAMP_ROUND_EN
    rounded = {1'b0, acc_d[AccW-1:FRAC_W]} + {{PHASE_W{1'b0}}, acc_d[FRAC_W-1]};
    phase_d = rounded[PHASE_W] ? {PHASE_W{1'b1}} : rounded[PHASE_W-1:0];
    if (reach) begin
      phase_d = end_q;
    end
`else
    phase_d = acc_d[AccW-1:FRAC_W];
`endif
    cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    abort   = bus.halt || bus.qcw_done;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      acc_q      <= '0;
      step_q     <= '0;
      end_q      <= '0;
      phase_q    <= '0;
      hold_q     <= '0;
      hold_cnt_q <= '0;
      cnt_q      <= '0;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start && !bus.halt) begin
            acc_q      <= {bus.phase_start, {FRAC_W{1'b0}}};
            step_q     <= bus.phase_step;
            end_q      <= bus.phase_end;
            hold_q     <= bus.hold_cycles;
            phase_q    <= bus.phase_start;
            dir_q      <= (bus.phase_end >= bus.phase_start);
            hold_cnt_q <= '0;
            cnt_q      <= '0;
            aborted_q  <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= (bus.phase_start == bus.phase_end) ? StHold : StRamp;
          end
        end
        StRamp: begin
          // Abort wins over a coincident cycle_finished: no step is applied.
          if (abort) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (bus.cycle_finished) begin
            cnt_q   <= cnt_inc;
            acc_q   <= acc_d;
            phase_q <= phase_d;
            if (reach) begin
              hold_cnt_q <= '0;
              state_q    <= StHold;
            end
          end
        end
        StHold: begin
          if (abort) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            aborted_q <= 1'b1;
          end else if (hold_cnt_q == hold_q) begin
            state_q <= StFinish;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (bus.cycle_finished) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
            cnt_q      <= cnt_inc;
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.phase_shift = phase_q;
  assign bus.busy        = busy_q;
  assign bus.ramp_done   = done_q;
  assign bus.aborted     = aborted_q;
  assign bus.cycle_count = cnt_q;

endmodule
